// File: rtl/text_console_writer.sv
// Turns a UART byte stream into character-RAM writes with a text cursor, control
// characters and row/screen clears; the video fetcher always wins the shared RAM port.
module text_console_writer #(
    parameter int         COLS   = 40,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 11,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_wr,
    input  logic [7:0]                i_data,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_we,
    output logic [7:0]                ram_din,
    output logic                      o_busy,
    output logic                      o_ovf,
    output logic [$clog2(COLS)-1:0]   o_col,
    output logic [$clog2(ROWS)-1:0]   o_row
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ROW_SPAN = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CLR_ROW = 2'd2,
        ST_CLR_ALL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          hold_q;
    logic                busy_q;
    logic                ovf_q;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;

    logic                accept_s;
    logic                done_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [7:0]          wr_data_s;
    logic [RW-1:0]       nl_row_s;
    logic [ADDR_W-1:0]   nl_base_s;

    assign accept_s = i_wr & ~busy_q;

    // Cursor position after a newline; row_base tracked by addition to avoid a multiplier
    always_comb begin
        if (row_q == ROW_LAST) begin
            nl_row_s  = '0;
            nl_base_s = '0;
        end else begin
            nl_row_s  = row_q + RW'(1);
            nl_base_s = base_q + COLS_A;
        end
    end

    // Next-state and writer request decode
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        base_d    = base_q;
        clr_d     = clr_q;
        done_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = base_q + ADDR_W'(col_q);
        wr_data_s = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (accept_s || busy_q) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (rd_req) begin
                    state_d = ST_EXEC;
                end else if (hold_q >= 8'h20 && hold_q <= 8'h7E) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = hold_q;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        row_d   = nl_row_s;
                        base_d  = nl_base_s;
                        clr_d   = nl_base_s;
                        state_d = ST_CLR_ROW;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    case (hold_q)
                        CH_CR: begin
                            col_d   = '0;
                            state_d = ST_IDLE;
                            done_s  = 1'b1;
                        end
                        CH_LF: begin
                            row_d   = nl_row_s;
                            base_d  = nl_base_s;
                            clr_d   = nl_base_s;
                            state_d = ST_CLR_ROW;
                        end
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d     = col_q - CW'(1);
                                wr_en_s   = 1'b1;
                                wr_addr_s = base_q + ADDR_W'(col_q) - ADDR_W'(1);
                                wr_data_s = BLANK;
                            end else begin
                                col_d = col_q;
                            end
                            state_d = ST_IDLE;
                            done_s  = 1'b1;
                        end
                        CH_FF: begin
                            col_d   = '0;
                            row_d   = '0;
                            base_d  = '0;
                            clr_d   = '0;
                            state_d = ST_CLR_ALL;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            done_s  = 1'b1;
                        end
                    endcase
                end
            end
            ST_CLR_ROW: begin
                if (!rd_req) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = clr_q;
                    wr_data_s = BLANK;
                    if (clr_q == base_q + ROW_SPAN) begin
                        state_d = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        clr_d = clr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_CLR_ROW;
                end
            end
            ST_CLR_ALL: begin
                if (!rd_req) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = clr_q;
                    wr_data_s = BLANK;
                    if (clr_q == SCR_LAST) begin
                        state_d = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        clr_d = clr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_CLR_ALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port arbitration: the video fetcher owns the port whenever it asks
    always_comb begin
        if (rd_req) begin
            ram_addr = rd_addr;
            ram_we   = 1'b0;
            ram_din  = 8'h00;
        end else begin
            ram_addr = wr_addr_s;
            ram_we   = wr_en_s;
            ram_din  = wr_data_s;
        end
    end

    // State, cursor, holding register and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'h00;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            clr_q   <= clr_d;
            if (accept_s) begin
                hold_q <= i_data;
                busy_q <= 1'b1;
            end else if (done_s) begin
                busy_q <= 1'b0;
            end
            if (i_wr && busy_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_busy = busy_q;
    assign o_ovf  = ovf_q;
    assign o_col  = col_q;
    assign o_row  = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: randomized bytes and video stalls checked against a
// cursor/screen model that computes addresses as row*COLS+col.
module tb_text_console_writer;

    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 11;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_wr    = 1'b0;
    logic [7:0]        i_data  = 8'h00;
    logic              rd_req  = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic              o_busy;
    logic              o_ovf;
    logic [CW-1:0]     o_col;
    logic [RW-1:0]     o_row;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int rd_mode = 0;
    int m_col = 0;
    int m_row = 0;
    logic [ADDR_W+7:0] got_q[$];
    logic [ADDR_W+7:0] exp_q[$];

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(8'h20)) dut (
        .clk(clk), .reset_n(reset_n), .i_wr(i_wr), .i_data(i_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .o_busy(o_busy), .o_ovf(o_ovf), .o_col(o_col), .o_row(o_row)
    );

    always #5 clk = ~clk;

    // video fetcher: idle, alternating, or random requests
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0: rd_req = 1'b0;
                1: rd_req = ~rd_req;
                default: rd_req = ($urandom_range(0, 3) == 0);
            endcase
            rd_addr = ADDR_W'($urandom);
        end
    end

    // RAM port monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_we) got_q.push_back({ram_addr, ram_din});
            if (rd_req && ram_we) viol++;
            if (rd_req && ram_addr !== rd_addr) viol++;
        end
    end

    function automatic void model_newline();
        m_row = (m_row + 1) % ROWS;
        for (int k = 0; k < COLS; k++) exp_q.push_back({ADDR_W'(m_row * COLS + k), 8'h20});
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({ADDR_W'(m_row * COLS + m_col), b});
            if (m_col == COLS - 1) begin
                m_col = 0;
                model_newline();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            model_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back({ADDR_W'(m_row * COLS + m_col), 8'h20});
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back({ADDR_W'(a), 8'h20});
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic strobe(input logic [7:0] b);
        @(posedge clk); #1;
        i_wr = 1'b1; i_data = b;
        @(posedge clk); #1;
        i_wr = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge clk);
            if (o_busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, output bit ok);
        strobe(b);
        model_byte(b);
        wait_idle(ok);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({o_busy, o_ovf, ram_we} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {o_busy, o_ovf, ram_we}); end
        total++; if (ram_din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h expected 00", ram_din); end
        total++; if (o_row !== RW'(0) || o_col !== CW'(0)) begin bad++; $display("FAIL reset_cursor: got %0d,%0d expected 0,0", o_row, o_col); end
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_a();
        clear_q();
        @(posedge clk); #1;
        i_wr = 1'b1; i_data = 8'h41;
        @(negedge clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL a_busy_before: got %b expected 0", o_busy); end
        @(posedge clk); #1;
        i_wr = 1'b0;
        @(negedge clk);
        total++; if ({o_busy, ram_we} !== 2'b11) begin bad++; $display("FAIL a_write: busy/we got %b expected 11", {o_busy, ram_we}); end
        total++; if ({ram_addr, ram_din} !== {ADDR_W'(0), 8'h41}) begin bad++; $display("FAIL a_addr_din: got %h/%h expected 0/41", ram_addr, ram_din); end
        @(negedge clk);
        total++; if ({o_busy, ram_we} !== 2'b00) begin bad++; $display("FAIL a_done: busy/we got %b expected 00", {o_busy, ram_we}); end
        total++; if (o_col !== CW'(1) || o_row !== RW'(0)) begin bad++; $display("FAIL a_cursor: got %0d,%0d expected 0,1", o_row, o_col); end
        model_byte(8'h41);
        clear_q();
    endtask

    task automatic test_row_fill();
        bit ok;
        int d;
        send(8'h0D, ok);
        clear_q();
        for (int i = 0; i < COLS; i++) begin
            send(8'($urandom_range(32, 126)), ok);
            total++; if (!ok) begin bad++; $display("FAIL fill_timeout: byte %0d got busy expected idle", i); end
        end
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL fill_writes: idx %0d got %0d writes expected %0d", d, got_q.size(), exp_q.size()); end
        total++; if (o_row !== RW'(1) || o_col !== CW'(0)) begin bad++; $display("FAIL fill_cursor: got %0d,%0d expected 1,0", o_row, o_col); end
    endtask

    task automatic test_lf_wrap();
        bit ok;
        int d;
        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)), ok);
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A, ok);
        total++; if (o_row !== RW'(29) || o_col !== CW'(5)) begin bad++; $display("FAIL lf_pre_cursor: got %0d,%0d expected 29,5", o_row, o_col); end
        clear_q();
        send(8'h0A, ok);
        d = first_diff();
        total++; if (d != -1 || got_q.size() != COLS) begin bad++; $display("FAIL lf_wrap_writes: idx %0d got %0d writes expected %0d", d, got_q.size(), COLS); end
        total++; if (o_row !== RW'(0) || o_col !== CW'(5)) begin bad++; $display("FAIL lf_wrap_cursor: got %0d,%0d expected 0,5", o_row, o_col); end
        clear_q();
        send(8'h0D, ok);
        send(8'h08, ok);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL cr_bs_nowrite: got %0d writes expected 0", got_q.size()); end
        total++; if (o_row !== RW'(0) || o_col !== CW'(0)) begin bad++; $display("FAIL cr_bs_cursor: got %0d,%0d expected 0,0", o_row, o_col); end
    endtask

    task automatic test_ff_toggle();
        int cyc;
        int d;
        bit fin;
        rd_mode = 1;
        @(posedge clk);
        viol = 0;
        clear_q();
        strobe(8'h0C);
        model_byte(8'h0C);
        cyc = 0;
        fin = 1'b0;
        for (int i = 0; i < 8000 && !fin; i++) begin
            @(negedge clk);
            if (o_busy === 1'b1) cyc++;
            else fin = 1'b1;
        end
        rd_mode = 0;
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL ff_writes: idx %0d got %0d writes expected %0d", d, got_q.size(), exp_q.size()); end
        total++; if (viol != 0) begin bad++; $display("FAIL ff_arbitration: got %0d violations expected 0", viol); end
        total++; if (cyc < 2401 || cyc > 2403) begin bad++; $display("FAIL ff_cycles: got %0d expected 2401..2403", cyc); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        logic [7:0] b1;
        b1 = 8'($urandom_range(32, 126));
        clear_q();
        @(posedge clk); #1;
        i_wr = 1'b1; i_data = b1;
        @(posedge clk); #1;
        i_data = 8'h5A;
        @(posedge clk); #1;
        i_wr = 1'b0;
        model_byte(b1);
        wait_idle(ok);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL b2b_writes: idx %0d got %0d writes expected %0d", d, got_q.size(), exp_q.size()); end
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL b2b_ovf: got %b expected 1", o_ovf); end
        send(8'h0D, ok);
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL b2b_ovf_sticky: got %b expected 1", o_ovf); end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        int d;
        logic [7:0] b;
        rd_mode = 2;
        @(posedge clk);
        viol = 0;
        clear_q();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'h0D;
            else if (r < 78) b = 8'h0A;
            else if (r < 89) b = 8'h08;
            else if (r < 90) b = 8'h0C;
            else b = 8'($urandom_range(0, 255));
            send(b, ok);
            total++; if (!ok || o_row !== RW'(m_row) || o_col !== CW'(m_col)) begin bad++; $display("FAIL rand_cursor: byte %h got %0d,%0d expected %0d,%0d", b, o_row, o_col, m_row, m_col); end
        end
        rd_mode = 0;
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL rand_writes: idx %0d got %0d writes expected %0d", d, got_q.size(), exp_q.size()); end
        total++; if (viol != 0) begin bad++; $display("FAIL rand_arbitration: got %0d violations expected 0", viol); end
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL rand_ovf_sticky: got %b expected 1", o_ovf); end
    endtask

    task automatic test_reset_mid_clr();
        rd_mode = 0;
        clear_q();
        strobe(8'h0C);
        for (int i = 0; i < 3000 && got_q.size() < 100; i++) @(negedge clk);
        total++; if (got_q.size() < 100) begin bad++; $display("FAIL rmc_progress: got %0d writes expected 100", got_q.size()); end
        @(posedge clk); #1;
        reset_n = 1'b0;
        m_col = 0;
        m_row = 0;
        got_q.delete();
        @(negedge clk);
        total++; if ({o_busy, o_ovf, ram_we, ram_din} !== 11'h000) begin bad++; $display("FAIL rmc_outputs: got %h expected 000", {o_busy, o_ovf, ram_we, ram_din}); end
        total++; if (o_row !== RW'(0) || o_col !== CW'(0)) begin bad++; $display("FAIL rmc_cursor: got %0d,%0d expected 0,0", o_row, o_col); end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (got_q.size() != 0 || o_busy !== 1'b0) begin bad++; $display("FAIL rmc_quiet: got %0d writes busy %b expected 0 writes busy 0", got_q.size(), o_busy); end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_row_fill();
        test_lf_wrap();
        test_ff_toggle();
        test_back_to_back();
        test_random();
        test_reset_mid_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Turns the received UART byte stream into writes to the screen character RAM, so incoming text appears on the VGA text display. The block keeps a cursor, interprets a small set of control characters, and clears rows and the screen. It shares the single RAM port with the video character fetcher, which always has priority. It sits between the UART receiver and the character RAM that feeds the font path.

## Interface
- COLS, 40, characters per row (≥2)
- ROWS, 30, rows per screen (≥2)
- ADDR_W, 11, RAM address width; COLS*ROWS ≤ 2^ADDR_W
- BLANK, 8'h20, fill character used by clears and backspace
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_wr  in  1  one-cycle strobe: i_data valid
- i_data  in  8  received byte
- rd_req  in  1  video fetcher requests the RAM port this cycle
- rd_addr  in  ADDR_W  video fetch address
- ram_addr  out  ADDR_W  shared RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  8  RAM write data
- o_busy  out  1  holding register occupied; a new byte would be dropped
- o_ovf  out  1  sticky: a byte arrived while busy; cleared only by reset
- o_col  out  ceil(log2 COLS)  cursor column
- o_row  out  ceil(log2 ROWS)  cursor row

## Operation
- Reset values: cursor (0,0), row base 0, FSM IDLE, o_busy 0, o_ovf 0, ram_we 0, ram_din 0.
- A reset asserted in any state aborts the operation immediately. Partially cleared RAM stays as it is.
- Holding register:
  - i_wr with o_busy=0 latches i_data and sets o_busy.
  - i_wr with o_busy=1 drops the byte and sets o_ovf.
- RAM address is row_base + col. row_base is kept incrementally: +COLS per row, reset to 0 on wrap. No multiplier.
- Arbitration (combinational):
  - rd_req=1: ram_addr=rd_addr, ram_we=0. Any pending writer action stalls and holds its state.
  - rd_req=0: ram_addr is the writer address. ram_we is 1 only in a write cycle.
- FSM states: IDLE, EXEC, CLR_ROW, CLR_ALL.
  - IDLE: o_busy=1 → EXEC.
  - EXEC decodes the held byte; exactly one action per byte:
    - 0x20–0x7E: write byte at cursor; col+1. At col=COLS-1: col=0, newline.
    - 0x0D (CR): col=0, no write.
    - 0x0A (LF): newline.
    - 0x08 (BS): if col>0, col-1 and write BLANK at the new position. If col=0, no-op.
    - 0x0C (FF): cursor (0,0), row_base 0, → CLR_ALL.
    - Any other byte: ignored.
  - Newline: row+1; at row=ROWS-1 wrap to row 0. Then → CLR_ROW to blank the new row. col is unchanged by LF.
  - CLR_ROW: writes BLANK at row_base+k, k=0..COLS-1. Cursor is unchanged.
  - CLR_ALL: writes BLANK at addresses 0..COLS*ROWS-1.
  - An action finishing without a clear returns to IDLE and clears o_busy. A finishing clear does the same.
- A printable write at end of row performs the write at the old address. It then enters CLR_ROW for the next row.

## Timing
- i_wr accepted at edge N → o_busy=1 after N.
- EXEC occupies cycle N+1. A printable/BS write asserts ram_we in N+1 if rd_req=0. The cursor updates at the end of the write cycle.
- Simple actions (write, CR, BS, ignored) clear o_busy at end of N+1 when not stalled, so a new byte is acceptable at edge N+2.
- CLR_ROW takes COLS unstalled cycles; CLR_ALL takes COLS*ROWS unstalled cycles. Each rd_req=1 cycle adds exactly one cycle.
- i_wr at the same edge o_busy falls: the byte is dropped (o_busy was 1 when sampled) and o_ovf is set.
- The cursor outputs are registered and reflect the state after each completed action.

## Test plan
- Reset mid CLR_ALL (after 100 writes) → all outputs at reset values next cycle; no further ram_we.
- Send 'A' (0x41) at reset, rd_req=0 → one ram_we at addr 0 with din 0x41; o_col=1; o_busy high for exactly 1 cycle.
- COLS=40: 40 printable bytes → writes at addr 0..39. The 40th is followed by 40 BLANK writes at 40..79; then o_row=1, o_col=0.
- Cursor (29,5), send LF → o_row=0, o_col=5; 40 BLANK writes at 0..39. Then CR, then BS → no write; cursor (0,0).
- FF with rd_req toggling 1/0 every cycle → 1200 BLANK writes (0..1199), none while rd_req=1; ram_addr=rd_addr whenever rd_req=1; total ≈2400 cycles.
- Two i_wr strobes one cycle apart → second byte dropped, o_ovf=1 and stays 1; only the first byte is written.
